// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_pkg
// Description : Shared types, derived widths and helpers for the multi-channel
//               time-multiplexed PID servo controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

  // One control slot per channel walks these five working states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MP   = 3'd2,
    MI   = 3'd3,
    MD   = 3'd4,
    SAT  = 3'd5
  } state_t;

  // Accumulator width large enough that OFFSET + kp*e + ki*i + kd*d never
  // overflows: sign + carry headroom, error, two gain products, integrator.
  function automatic int acc_width(input int pos_w, input int gain_w, input int int_w);
    return 2 + pos_w + 2 * gain_w + int_w;
  endfunction

  localparam int DEF_POS_W  = 12;
  localparam int DEF_GAIN_W = 16;
  localparam int DEF_INT_W  = 24;
  localparam int ACC_W      = acc_width(DEF_POS_W, DEF_GAIN_W, DEF_INT_W);

  // Symmetric saturation of the integrator candidate to +/-lim.
  function automatic logic signed [63:0] clamp_sym(input logic signed [63:0] v,
                                                   input logic signed [63:0] lim);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mac.sv
`default_nettype none
// ============================================================================
// Module      : pid_mac
// Description : Signed multiply-accumulate with a single multiplier shared by
//               every control phase and every channel.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_mac #(
  parameter int A_W   = 17,
  parameter int B_W   = 24,
  parameter int ACC_W = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_acc_en,
  input  logic signed [ACC_W-1:0] i_load_val,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  // Load the bias value or add the current product into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_acc_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pid_servo_multi.sv
`default_nettype none
// ============================================================================
// Module      : pid_servo_multi
// Description : Time-multiplexed N-channel PID position controller producing
//               registered PWM duty values through one shared MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_servo_multi
  import pid_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int POS_W    = 12,
  parameter int DUTY_W   = 18,
  parameter int GAIN_W   = 16,
  parameter int INT_W    = 24,
  parameter int INT_LIM  = 2**20,
  parameter int MIN_DUTY = 50000,
  parameter int OFFSET   = 75000,
  parameter int MAX_DUTY = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [GAIN_W-1:0]        kp,
  input  logic [GAIN_W-1:0]        ki,
  input  logic [GAIN_W-1:0]        kd,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*POS_W-1:0]    setpoint,
  input  logic [N_CH*POS_W-1:0]    feedback,
  output logic [N_CH*DUTY_W-1:0]   duty_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int E_W     = POS_W + 1;
  localparam int D_W     = POS_W + 2;
  localparam int A_W     = GAIN_W + 1;
  localparam int B_W     = (INT_W > D_W) ? INT_W : D_W;
  localparam int c_acc_w = acc_width(POS_W, GAIN_W, INT_W);

  localparam logic signed [c_acc_w-1:0] c_acc_off = c_acc_w'(OFFSET);
  localparam logic signed [c_acc_w-1:0] c_acc_max = c_acc_w'(MAX_DUTY);
  localparam logic signed [c_acc_w-1:0] c_acc_min = c_acc_w'(MIN_DUTY);
  localparam logic [DUTY_W-1:0]         c_duty_off = DUTY_W'(OFFSET);
  localparam logic [DUTY_W-1:0]         c_duty_max = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0]         c_duty_min = DUTY_W'(MIN_DUTY);

  state_t                    r_state;
  state_t                    w_next;
  logic [CH_W-1:0]           r_ch;

  // Round snapshot of all inputs
  logic [N_CH*POS_W-1:0]     r_sp;
  logic [N_CH*POS_W-1:0]     r_fb;
  logic [GAIN_W-1:0]         r_kp;
  logic [GAIN_W-1:0]         r_ki;
  logic [GAIN_W-1:0]         r_kd;
  logic [N_CH-1:0]           r_en;

  // Per-channel controller memory
  logic signed [INT_W-1:0]   r_integ [N_CH];
  logic signed [E_W-1:0]     r_last  [N_CH];
  logic [DUTY_W-1:0]         r_duty  [N_CH];

  // Terms of the channel currently in its slot
  logic [POS_W-1:0]          w_sp_cur;
  logic [POS_W-1:0]          w_fb_cur;
  logic signed [E_W-1:0]     w_e;
  logic signed [E_W-1:0]     r_e;
  logic signed [D_W-1:0]     w_d;
  logic signed [D_W-1:0]     r_d;
  logic signed [INT_W-1:0]   w_icand;
  logic signed [INT_W-1:0]   r_icand;

  logic                      w_last_ch;
  logic                      w_busy;
  logic                      w_snap;
  logic                      w_mac_load;
  logic                      w_mac_acc;
  logic signed [A_W-1:0]     w_a;
  logic signed [B_W-1:0]     w_b;
  logic signed [c_acc_w-1:0] w_acc;
  logic                      w_sat_hi;
  logic                      w_sat_lo;
  logic                      w_hold;
  logic [DUTY_W-1:0]         w_sat_duty;
  logic                      r_done;
  logic                      r_overrun;

  assign w_last_ch = (r_ch == CH_W'(N_CH - 1));

  // Error, derivative and clamped integrator candidate from the snapshot
  assign w_sp_cur = r_sp[r_ch*POS_W +: POS_W];
  assign w_fb_cur = r_fb[r_ch*POS_W +: POS_W];
  assign w_e      = $signed({1'b0, w_sp_cur}) - $signed({1'b0, w_fb_cur});
  assign w_d      = {w_e[E_W-1], w_e} - {r_last[r_ch][E_W-1], r_last[r_ch]};
  assign w_icand  = INT_W'(clamp_sym(64'(r_integ[r_ch]) + 64'(w_e), 64'(INT_LIM)));

  // Output limiting and anti-windup decision on the finished accumulator
  assign w_sat_hi   = (w_acc > c_acc_max);
  assign w_sat_lo   = (w_acc < c_acc_min);
  assign w_hold     = (w_sat_hi && !r_e[E_W-1] && (r_e != '0)) || (w_sat_lo && r_e[E_W-1]);
  assign w_sat_duty = w_sat_hi ? c_duty_max : (w_sat_lo ? c_duty_min : w_acc[DUTY_W-1:0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: five fixed phases per channel, then next channel or idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next = ERR;
      ERR:     w_next = MP;
      MP:      w_next = MI;
      MI:      w_next = MD;
      MD:      w_next = SAT;
      SAT:     w_next = w_last_ch ? IDLE : ERR;
      default: w_next = IDLE;
    endcase
  end

  // Per-state controls: MAC load/accumulate and operand selection
  always_comb begin
    w_busy     = (r_state != IDLE);
    w_snap     = (r_state == IDLE) && sample_tick;
    w_mac_load = 1'b0;
    w_mac_acc  = 1'b0;
    w_a        = '0;
    w_b        = '0;
    case (r_state)
      ERR: w_mac_load = 1'b1;
      MP: begin
        w_mac_acc = 1'b1;
        w_a       = $signed({1'b0, r_kp});
        w_b       = B_W'(r_e);
      end
      MI: begin
        w_mac_acc = 1'b1;
        w_a       = $signed({1'b0, r_ki});
        w_b       = B_W'(r_icand);
      end
      MD: begin
        w_mac_acc = 1'b1;
        w_a       = $signed({1'b0, r_kd});
        w_b       = B_W'(r_d);
      end
      default: ;
    endcase
  end

  pid_mac #(
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (c_acc_w)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mac_load),
    .i_acc_en   (w_mac_acc),
    .i_load_val (c_acc_off),
    .i_a        (w_a),
    .i_b        (w_b),
    .o_acc      (w_acc)
  );

  // Snapshot, per-channel term capture, write-back and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch      <= '0;
      r_sp      <= '0;
      r_fb      <= '0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_kd      <= '0;
      r_en      <= '0;
      r_e       <= '0;
      r_d       <= '0;
      r_icand   <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_integ[i] <= '0;
        r_last[i]  <= '0;
        r_duty[i]  <= c_duty_off;
      end
    end else begin
      r_done    <= (r_state == SAT) && w_last_ch;
      r_overrun <= sample_tick && (r_state != IDLE);
      if (w_snap) begin
        r_sp <= setpoint;
        r_fb <= feedback;
        r_kp <= kp;
        r_ki <= ki;
        r_kd <= kd;
        r_en <= ch_en;
        r_ch <= '0;
      end
      if (r_state == ERR) begin
        r_e     <= w_e;
        r_d     <= w_d;
        r_icand <= w_icand;
      end
      if (r_state == SAT) begin
        if (!r_en[r_ch]) begin
          // Disabled channel parks at neutral and forgets its history
          r_duty[r_ch]  <= c_duty_off;
          r_integ[r_ch] <= '0;
          r_last[r_ch]  <= '0;
        end else begin
          r_duty[r_ch] <= w_sat_duty;
          if (!w_hold) begin
            r_integ[r_ch] <= r_icand;
          end
          r_last[r_ch] <= r_e;
        end
        if (!w_last_ch) begin
          r_ch <= r_ch + 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_duty
      assign duty_out[g*DUTY_W +: DUTY_W] = r_duty[g];
    end
  endgenerate

  assign busy    = w_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/pid_servo_multi.md
# pid_servo_multi

Time-multiplexed, multi-channel PID position controller. It replaces the single-channel servo PID loop. It drives N_CH servo PWM generators from one shared multiply-accumulate datapath. Each channel gets runtime gains, a sample-tick cadence, integrator clamping with anti-windup, and per-channel enable. It sits between the position-target/feedback registers and the PWM duty inputs.

## Interface
- N_CH, 4, number of servo channels (1..16)
- POS_W, 12, unsigned position width (setpoint and feedback)
- DUTY_W, 18, duty output width
- GAIN_W, 16, unsigned gain width
- INT_W, 24, signed integrator width
- INT_LIM, 2**20, integrator clamp magnitude (±INT_LIM)
- MIN_DUTY, 50000, duty floor (0°)
- OFFSET, 75000, duty at zero control effort (90°)
- MAX_DUTY, 100000, duty ceiling (180°)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_tick  in  1  single-cycle pulse that starts one control round
- kp, ki, kd  in  GAIN_W each  gains, snapshotted on tick acceptance
- ch_en  in  N_CH  channel enable mask, snapshotted on tick acceptance
- setpoint  in  N_CH*POS_W  packed desired positions, channel 0 in LSBs
- feedback  in  N_CH*POS_W  packed measured positions
- duty_out  out  N_CH*DUTY_W  packed registered duty values
- busy  out  1  round in progress
- done  out  1  one-cycle pulse when the round's last duty is written
- overrun  out  1  one-cycle pulse when a tick is dropped

## Operation
- One clock and one reset are decided: the clock is clk; the reset is rst, asynchronous and active-high.
- Reset values:
  - duty_out: every channel = OFFSET.
  - busy, done, overrun: 0.
  - Integrator and last_error: 0 for every channel.
  - FSM: IDLE.
- FSM states: IDLE, ERR, MP, MI, MD, SAT.
- IDLE:
  - A sample_tick snapshots setpoint, feedback, gains and ch_en.
  - It then sets ch=0 and moves to ERR.
- ERR:
  - e = zero-extend(sp) − zero-extend(fb), signed POS_W+1 bits.
  - d = e − last_error[ch].
  - i_cand = clamp(integ[ch] + e, ±INT_LIM).
  - Accumulator loads OFFSET.
- MP: acc += kp·e.
- MI: acc += ki·i_cand.
- MD: acc += kd·d.
- SAT:
  - acc > MAX_DUTY → duty = MAX_DUTY, flagged saturated-high.
  - acc < MIN_DUTY → duty = MIN_DUTY, flagged saturated-low.
  - Otherwise duty = acc[DUTY_W-1:0].
  - Anti-windup: integ[ch] keeps its old value if saturated-high with e>0, or saturated-low with e<0. Otherwise integ[ch] takes i_cand.
  - last_error[ch] takes e in all cases.
  - Next state: ch<N_CH−1 → ch+1 and ERR; otherwise IDLE.
- Disabled channel (snapshot ch_en[ch]=0):
  - Still spends 5 cycles in its slot.
  - In SAT it writes duty = OFFSET and clears integ and last_error.
- Accumulator is signed, at least 2+POS_W+2·GAIN_W+INT_W bits; no intermediate overflow.
- A sample_tick outside IDLE is ignored and pulses overrun for that cycle. The running round continues unchanged.
- Input changes after the snapshot have no effect until the next round.

## Timing
- A tick sampled in IDLE at edge T: busy=1 from T, ERR for ch0 in cycle T..T+1.
- Channel c's duty updates at edge T+5(c+1). Other channels hold their values.
- At edge T+5·N_CH: busy falls and done rises for exactly one cycle.
- A tick in that done cycle is accepted, giving a minimum tick period of 5·N_CH+1 cycles.
- rst asserted mid-round: all outputs and state return to reset values immediately. The partial round is discarded.
- Simultaneous tick and rst: rst wins.

## Structure
- Package pid_pkg holds:
  - the state enum (IDLE, ERR, MP, MI, MD, SAT);
  - a derived localparam for the accumulator width;
  - a clamp function for the integrator.
- One sub-module, pid_mac:
  - a signed multiply-accumulate, load/accumulate controlled by the FSM;
  - a single multiplier shared by all phases and channels.
- Per-channel integ and last_error are register arrays, indexed by ch.

## Test plan
Defaults, N_CH=4, kp=100, ki=1, kd=10 unless stated.
- **Reset:** rst pulse, then release → all four duty_out = 75000, busy=0, done=0.
- **Small step:** ch0 sp=2048, fb=2000, tick.
  - After round 1: duty[0]=80328 (75000+4800+48+480).
  - Round 2, same inputs: 79896. Sequence done at T+20.
- **Positive saturation with anti-windup:** ch1 sp=2400, fb=2000 → duty[1]=100000, integrator stays 0.
  - Next round with sp=fb → duty[1]=71000 (75000−4000).
- **Negative saturation:** ch2 sp=1600, fb=2000 → duty[2]=50000, integrator stays 0.
- **Overrun:** tick at T, second tick at T+7 → overrun pulses at T+7, done only at T+20, no restart.
- **Disable and mid-round reset:**
  - ch_en=4'b1011 with ch2 error 48 → duty[2]=75000 and its integrator cleared.
  - rst at T+8 → all duty_out=75000, busy=0 on the same cycle.
